// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: FSM states and bus-level bit constants.
// Imported by i2c_line_filter and i2c_target.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDRESS,
        ST_ADDRESS_ACK,
        ST_OFFSET,
        ST_OFFSET_ACK,
        ST_WRITE_DATA,
        ST_WRITE_ACK,
        ST_READ_DATA,
        ST_READ_ACK,
        ST_IGNORE
    } i2c_state_t;

    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-FF synchronizer, run-length glitch filter, edge pulses.
// The filtered level only changes after FILTER_CYCLES equal samples.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic line_input,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic [3:0] count;
    logic       accept;

    assign accept = (sync[1] != level)
                 && (count == 4'(FILTER_CYCLES - 1));

    // Synchronize, count differing samples, flip level on a full run.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            count <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_input};
            rise <= accept & sync[1];
            fall <= accept & ~sync[1];
            if (sync[1] == level) begin
                count <= '0;
            end else if (accept) begin
                level <= sync[1];
                count <= '0;
            end else begin
                count <= count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address and 8-bit auto-incrementing offset port.
// Define I2C_TARGET_STRETCH_EN to hold SCL low after every ACK/NACK bit.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int         CLOCK_FREQUENCY = 200_000_000,
    parameter logic [6:0] ADDRESS         = 7'h54,
    parameter int         FILTER_CYCLES   = 4,
    parameter int         STRETCH_CYCLES  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_input,
    output logic       scl_output,
    input  logic       sda_input,
    output logic       sda_output,
    output logic       write_valid,
    output logic [7:0] write_offset,
    output logic [7:0] write_data,
    output logic       read_valid,
    output logic [7:0] read_offset,
    input  logic [7:0] read_data,
    output logic       busy
);

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter
        $error("i2c_target: FILTER_CYCLES must be 1..15");
    end
    if (STRETCH_CYCLES < 2 || STRETCH_CYCLES > CLOCK_FREQUENCY / 100_000) begin : g_bad_stretch
        $error("i2c_target: STRETCH_CYCLES out of range");
    end

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_seen, stop_seen, load_now;

    i2c_state_t state, state_next;
    logic [3:0] bit_cnt, bit_next;
    logic [7:0] shift, shift_next;
    logic [7:0] offset, offset_next;
    logic       rw, rw_next;
    logic [1:0] load_cnt, load_next;
    logic       busy_next, sda_next;
    logic       write_valid_next, read_valid_next;
    logic [7:0] write_offset_next, write_data_next, read_offset_next;
    logic [7:0] byte_in;

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl (
        .clock(clock), .reset(reset), .line_input(scl_input),
        .level(scl_level), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda (
        .clock(clock), .reset(reset), .line_input(sda_input),
        .level(sda_level), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_seen = scl_level & sda_fall;
    assign stop_seen  = scl_level & sda_rise;
    assign byte_in    = {shift[6:0], sda_level};

`ifdef I2C_TARGET_STRETCH_EN
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    logic [SW-1:0] stretch_cnt;
    logic          ack_end;

    assign ack_end = scl_fall && !start_seen && !stop_seen
                  && (state inside {ST_ADDRESS_ACK, ST_OFFSET_ACK,
                                    ST_WRITE_ACK, ST_READ_ACK});

    // Hold SCL low for a fixed run after each acknowledge bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stretch_cnt <= '0;
        end else if (ack_end) begin
            stretch_cnt <= SW'(STRETCH_CYCLES);
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - SW'(1);
        end
    end

    assign scl_output = (stretch_cnt == '0);
    assign load_now   = (load_cnt != 2'd0) && (stretch_cnt == SW'(1));
`else
    assign scl_output = 1'b1;
    assign load_now   = (load_cnt == 2'd1);
`endif

    // Next-state and output decode; START/STOP override bit handling.
    always_comb begin
        state_next        = state;
        bit_next          = bit_cnt;
        shift_next        = shift;
        offset_next       = offset;
        rw_next           = rw;
        load_next         = load_cnt;
        busy_next         = busy;
        sda_next          = sda_output;
        write_valid_next  = 1'b0;
        write_offset_next = write_offset;
        write_data_next   = write_data;
        read_valid_next   = 1'b0;
        read_offset_next  = read_offset;
        if (stop_seen) begin
            state_next = ST_IDLE;
            sda_next   = NACK;
            busy_next  = 1'b0;
            load_next  = '0;
        end else if (start_seen) begin
            state_next = ST_ADDRESS;
            bit_next   = '0;
            sda_next   = NACK;
            load_next  = '0;
        end else begin
            unique case (state)
                ST_ADDRESS, ST_OFFSET, ST_WRITE_DATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_next = byte_in;
                        bit_next   = bit_cnt + 4'd1;
                        if (state == ST_WRITE_DATA && bit_cnt == 4'd7) begin
                            write_valid_next  = 1'b1;
                            write_offset_next = offset;
                            write_data_next   = byte_in;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_next = '0;
                        sda_next = ACK;
                        if (state == ST_OFFSET) begin
                            state_next  = ST_OFFSET_ACK;
                            offset_next = shift;
                        end else if (state == ST_WRITE_DATA) begin
                            state_next = ST_WRITE_ACK;
                        end else if (shift[7:1] == ADDRESS) begin
                            state_next = ST_ADDRESS_ACK;
                            rw_next    = shift[0];
                            busy_next  = 1'b1;
                        end else begin
                            state_next = ST_IGNORE;
                            sda_next   = NACK;
                            busy_next  = 1'b0;
                        end
                    end
                end
                ST_ADDRESS_ACK, ST_OFFSET_ACK, ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_next = NACK;
                        bit_next = '0;
                        if (state == ST_WRITE_ACK) begin
                            state_next  = ST_WRITE_DATA;
                            offset_next = offset + 8'd1;
                        end else if (state == ST_OFFSET_ACK) begin
                            state_next = ST_WRITE_DATA;
                        end else if (rw == I2C_READ) begin
                            state_next       = ST_READ_DATA;
                            read_valid_next  = 1'b1;
                            read_offset_next = offset;
                            load_next        = 2'd2;
                        end else begin
                            state_next = ST_OFFSET;
                        end
                    end
                end
                ST_READ_DATA: begin
                    if (load_now) begin
                        shift_next = read_data;
                        sda_next   = read_data[7];
                        load_next  = '0;
                    end else if (load_cnt > 2'd1) begin
                        load_next = load_cnt - 2'd1;
                    end
                    if (scl_rise && bit_cnt != 4'd8) begin
                        bit_next = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_next  = ST_READ_ACK;
                        sda_next    = NACK;
                        bit_next    = '0;
                        offset_next = offset + 8'd1;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        shift_next = {shift[6:0], 1'b0};
                        sda_next   = shift[6];
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        shift_next[0] = sda_level;
                    end else if (scl_fall) begin
                        if (shift[0] == ACK) begin
                            state_next       = ST_READ_DATA;
                            read_valid_next  = 1'b1;
                            read_offset_next = offset;
                            load_next        = 2'd2;
                        end else begin
                            state_next = ST_IGNORE;
                            busy_next  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            offset       <= '0;
            rw           <= I2C_WRITE;
            load_cnt     <= '0;
            busy         <= 1'b0;
            sda_output   <= 1'b1;
            write_valid  <= 1'b0;
            write_offset <= '0;
            write_data   <= '0;
            read_valid   <= 1'b0;
            read_offset  <= '0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_next;
            shift        <= shift_next;
            offset       <= offset_next;
            rw           <= rw_next;
            load_cnt     <= load_next;
            busy         <= busy_next;
            sda_output   <= sda_next;
            write_valid  <= write_valid_next;
            write_offset <= write_offset_next;
            write_data   <= write_data_next;
            read_valid   <= read_valid_next;
            read_offset  <= read_offset_next;
        end
    end

endmodule
